// File: rtl/mem_text_streamer_if.sv
// rtl/mem_text_streamer_if.sv - memory scan port and byte stream bundle for mem_text_streamer
interface mem_text_streamer_if;
  logic [31:0] scan_addr;
  logic [31:0] scan_data;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport master (
    output scan_addr,
    output byte_out,
    output byte_valid,
    input  scan_data,
    input  byte_ready
  );

  modport slave (
    input  scan_addr,
    input  byte_out,
    input  byte_valid,
    output scan_data,
    output byte_ready
  );
endinterface

// File: rtl/mem_text_streamer.sv
// rtl/mem_text_streamer.sv - walks a word region of data memory and streams its bytes little-endian
module mem_text_streamer #(
  parameter int unsigned BASE_WORD   = 0,
  parameter int unsigned NUM_WORDS   = 128,
  parameter bit          STOP_ON_NUL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  mem_text_streamer_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           bytes_sent
);

  localparam int IDXW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idx_inc;
  logic [1:0]      sel;
  logic [1:0]      next_sel;
  logic [31:0]     word_buf;
  logic [7:0]      next_byte;
  logic            transfer;
  logic [15:0]     sent_inc;

  assign idx_inc   = idx + IDXW'(1);
  assign next_sel  = sel + 2'd1;
  assign next_byte = word_buf[{next_sel, 3'b000} +: 8];
  assign transfer  = bus.byte_valid & bus.byte_ready;
  assign sent_inc  = (bytes_sent == 16'hFFFF) ? bytes_sent : bytes_sent + 16'd1;

  function automatic logic is_nul(input logic [7:0] b);
    return STOP_ON_NUL && (b == 8'h00);
  endfunction

  // byte_out/byte_valid are loaded one step ahead so SEND never looks at byte_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      sel            <= '0;
      word_buf       <= '0;
      bytes_sent     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
      bus.scan_addr  <= 32'(BASE_WORD);
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx           <= '0;
            sel           <= '0;
            bytes_sent    <= '0;
            bus.scan_addr <= 32'(BASE_WORD);
            busy          <= 1'b1;
            state         <= S_FETCH;
          end
        end
        S_FETCH: begin
          word_buf       <= bus.scan_data;
          sel            <= '0;
          bus.byte_out   <= bus.scan_data[7:0];
          bus.byte_valid <= !is_nul(bus.scan_data[7:0]);
          state          <= S_SEND;
        end
        S_SEND: begin
          if (is_nul(bus.byte_out)) begin
            bus.byte_valid <= 1'b0;
            done           <= 1'b1;
            state          <= S_DONE;
          end else if (transfer) begin
            bytes_sent <= sent_inc;
            if (sel != 2'd3) begin
              sel            <= next_sel;
              bus.byte_out   <= next_byte;
              bus.byte_valid <= !is_nul(next_byte);
            end else begin
              bus.byte_valid <= 1'b0;
              if (idx != LAST_IDX) begin
                idx           <= idx_inc;
                bus.scan_addr <= 32'(BASE_WORD) + 32'(idx_inc);
                state         <= S_FETCH;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_text_streamer.sv
// tb/tb_mem_text_streamer.sv - scoreboard bench for mem_text_streamer with two parameterisations
module tb_mem_text_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ra = 1'b1, rb = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] sent_a, sent_b;
  logic [31:0] mem [0:1023];

  mem_text_streamer_if ifa ();
  mem_text_streamer_if ifb ();

  assign ifa.scan_data = mem[ifa.scan_addr[9:0]];
  assign ifb.scan_data = mem[ifb.scan_addr[9:0]];

  mem_text_streamer #(.BASE_WORD(500), .NUM_WORDS(4), .STOP_ON_NUL(1'b1)) dut_a (
    .clk(clk), .rst(ra), .start(start_a), .bus(ifa.master),
    .busy(busy_a), .done(done_a), .bytes_sent(sent_a)
  );

  mem_text_streamer #(.BASE_WORD(0), .NUM_WORDS(2), .STOP_ON_NUL(1'b0)) dut_b (
    .clk(clk), .rst(rb), .start(start_b), .bus(ifb.master),
    .busy(busy_b), .done(done_b), .bytes_sent(sent_b)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0]  b;
    logic [31:0] a;
  } exp_t;

  exp_t qa[$], qb[$];
  int   na[$], nb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  // Reference: bytes of the region in little-endian order, cut at the first NUL when enabled
  task automatic push_model(input bit a_side);
    int unsigned base = a_side ? 500 : 0;
    int          nw   = a_side ? 4 : 2;
    bit          stop = a_side;
    bit          ended = 0;
    int          cnt = 0;
    exp_t        e;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
        logic [31:0] word;
        word = mem[base + w];
        e.b = word[8*k +: 8];
        e.a = base + w;
        if (!ended) begin
          if (stop && e.b == 8'h00) ended = 1;
          else begin
            if (a_side) qa.push_back(e); else qb.push_back(e);
            cnt++;
          end
        end
      end
    end
    if (a_side) na.push_back(cnt); else nb.push_back(cnt);
  endtask

  logic       stall_a = 0, stall_b = 0;
  logic [7:0] held_a, held_b;
  exp_t       ea, eb;

  always @(negedge clk) begin
    if (ra) stall_a = 0;
    else begin
      if (stall_a) begin
        check("a_hold_valid", ifa.byte_valid, 1'b1);
        check("a_hold_byte", ifa.byte_out, held_a);
      end
      if (ifa.byte_valid && ifa.byte_ready) begin
        if (qa.size() == 0) fail("a_extra_byte");
        else begin
          ea = qa.pop_front();
          check("a_byte", ifa.byte_out, ea.b);
          check("a_addr", ifa.scan_addr, ea.a);
        end
      end
      stall_a = ifa.byte_valid && !ifa.byte_ready;
      held_a  = ifa.byte_out;
      if (done_a) begin
        if (na.size() == 0) fail("a_spurious_done");
        else begin
          check("a_bytes_sent", sent_a, na.pop_front());
          check("a_bytes_missing", qa.size(), 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rb) stall_b = 0;
    else begin
      if (stall_b) begin
        check("b_hold_valid", ifb.byte_valid, 1'b1);
        check("b_hold_byte", ifb.byte_out, held_b);
      end
      if (ifb.byte_valid && ifb.byte_ready) begin
        if (qb.size() == 0) fail("b_extra_byte");
        else begin
          eb = qb.pop_front();
          check("b_byte", ifb.byte_out, eb.b);
          check("b_addr", ifb.scan_addr, eb.a);
        end
      end
      stall_b = ifb.byte_valid && !ifb.byte_ready;
      held_b  = ifb.byte_out;
      if (done_b) begin
        if (nb.size() == 0) fail("b_spurious_done");
        else begin
          check("b_bytes_sent", sent_b, nb.pop_front());
          check("b_bytes_missing", qb.size(), 0);
        end
      end
    end
  end

  // mode 0: random ready, stray starts, memory scribbles; 1: ready high; 2: stall 2nd byte 3 cycles
  task automatic run_scan(input bit a_side, input int mode);
    int         k = 0;
    bit         seen = 0;
    logic [31:0] first_word;
    first_word = a_side ? mem[500] : mem[0];
    push_model(a_side);
    if (a_side) begin ifa.byte_ready = (mode != 0); start_a = 1; end
    else begin ifb.byte_ready = (mode != 0); start_b = 1; end
    do begin
      @(posedge clk); #1;
      k++;
      start_a = 0;
      start_b = 0;
      if (a_side ? done_a : done_b) seen = 1;
      else if (mode == 0) begin
        if (a_side) ifa.byte_ready = ($urandom_range(0, 3) != 0);
        else ifb.byte_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) begin
          if (a_side) start_a = 1; else start_b = 1;
        end
        if (a_side && ifa.byte_valid && $urandom_range(0, 5) == 0)
          mem[ifa.scan_addr[9:0]] = $urandom;
      end else if (mode == 2) begin
        ifb.byte_ready = !(k >= 3 && k <= 5);
        if (k >= 3 && k <= 5) begin
          check("bp_valid", ifb.byte_valid, 1'b1);
          check("bp_byte", ifb.byte_out, first_word[15:8]);
        end
      end
    end while (!seen && k < 2000);
    if (!seen) fail("scan_timeout");
    @(posedge clk); #1;
  endtask

  task automatic fill_a();
    for (int w = 500; w < 504; w++)
      for (int k = 0; k < 4; k++)
        mem[w][8*k +: 8] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    ifa.byte_ready = 0;
    ifb.byte_ready = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    ra = 0;
    rb = 0;

    check("rst_a_valid", ifa.byte_valid, 1'b0);
    check("rst_a_busy", busy_a, 1'b0);
    check("rst_a_done", done_a, 1'b0);
    check("rst_a_byte", ifa.byte_out, 8'h00);
    check("rst_a_addr", ifa.scan_addr, 32'd500);
    check("rst_a_sent", sent_a, 16'd0);
    check("rst_b_addr", ifb.scan_addr, 32'd0);
    check("rst_b_busy", busy_b, 1'b0);

    // Latency and NUL termination: bytes in cycles 2..5, done in cycle 8
    mem[500] = 32'h64636261;
    mem[501] = 32'h0;
    push_model(1);
    ifa.byte_ready = 1;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    for (int c = 1; c <= 8; c++) begin
      check("t1_valid", ifa.byte_valid, (c >= 2 && c <= 5));
      check("t1_done", done_a, (c == 8));
      check("t1_busy", busy_a, 1'b1);
      if (c < 8) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    check("t1_idle", busy_a, 1'b0);
    check("t1_sent_hold", sent_a, 16'd4);

    mem[0] = 32'h44332211;
    mem[1] = $urandom;
    run_scan(0, 2);

    mem[0] = 32'h00FF0011;
    mem[1] = 32'h00FF0011;
    run_scan(0, 1);
    check("t3_sent_hold", sent_b, 16'd8);

    for (int i = 0; i < 25; i++) begin
      fill_a();
      run_scan(1, 0);
      mem[0] = $urandom;
      mem[1] = $urandom;
      run_scan(0, 0);
    end

    // Reset while word 1 is being sent aborts the scan with no done pulse
    for (int w = 500; w < 504; w++) mem[w] = $urandom | 32'h01010101;
    push_model(1);
    ifa.byte_ready = 1;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    k = 0;
    while (!(ifa.scan_addr == 32'd501 && ifa.byte_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) fail("t5_reach_word1");
    ra = 1;
    qa.delete();
    na.delete();
    @(posedge clk); #1;
    check("t5_valid", ifa.byte_valid, 1'b0);
    check("t5_busy", busy_a, 1'b0);
    check("t5_done", done_a, 1'b0);
    check("t5_byte", ifa.byte_out, 8'h00);
    check("t5_addr", ifa.scan_addr, 32'd500);
    check("t5_sent", sent_a, 16'd0);
    ra = 0;
    repeat (20) begin @(posedge clk); #1; end
    check("t5_still_idle", busy_a, 1'b0);
    run_scan(1, 1);
    check("t5_rescan_sent", sent_a, 16'd16);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
